scs8hd_rstseq_4: RTL and testbench

//  Reset synchronizer and sequencer feeding the RESETB pins of downstream dfrtp flop banks.

---
 rtl/scs8hd_rstseq_4.sv | 149 ++++++++++++++
 tb/tb_scs8hd_rstseq_4.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/scs8hd_rstseq_4.sv
// Reset synchronizer and sequencer: asserts all domain resets asynchronously and
// releases them synchronously, one domain at a time, with a req/ack software reset.
`timescale 1ns/1ps
module scs8hd_rstseq_4 #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NDOM        = 4,
    parameter int unsigned GAP         = 8,
    parameter int unsigned SWRST_LEN   = 16
) (
    input  logic            CLK,
    input  logic            RESETB,
    input  logic            SWRST_REQ,
    output logic            SWRST_ACK,
    output logic [NDOM-1:0] RESETB_OUT,
    output logic            READY
);

    localparam int unsigned CNT_MAX = (GAP > SWRST_LEN) ? GAP : SWRST_LEN;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = (NDOM > 1) ? $clog2(NDOM) : 1;

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] SW_LAST  = CNT_W'(SWRST_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDOM - 1);

    typedef enum logic [1:0] {
        StHold,
        StRelease,
        StRun,
        StSwrst
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NDOM-1:0]    out_q, out_d;
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;
    logic               sw_q, sw_d;

    // Deassertion synchronizer; every stage is cleared asynchronously.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q <= StHold;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            sw_q    <= sw_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;
        ready_d = ready_q;
        ack_d   = ack_q;
        sw_d    = sw_q;

        unique case (state_q)
            StHold: begin
                if (rst_sync) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            StRelease: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    // Rebuild the thermometer up to idx so the output can never skip a domain.
                    for (int unsigned i = 0; i < NDOM; i++) begin
                        if (32'(idx_q) >= i) begin
                            out_d[i] = 1'b1;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = StRun;
                        ready_d = 1'b1;
                        ack_d   = sw_q;
                        sw_d    = 1'b0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StRun: begin
                if (ack_q) begin
                    if (!SWRST_REQ) begin
                        ack_d = 1'b0;
                    end
                end else if (SWRST_REQ) begin
                    state_d = StSwrst;
                    out_d   = '0;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    sw_d    = 1'b1;
                end
            end

            StSwrst: begin
                if (cnt_q == SW_LAST) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StHold;
            end
        endcase
    end

    assign RESETB_OUT = out_q;
    assign READY      = ready_q;
    assign SWRST_ACK  = ack_q;

endmodule

// File: tb/tb_scs8hd_rstseq_4.sv
// Randomized bench for scs8hd_rstseq_4 against a schedule-based reference model.
`timescale 1ns/1ps
module tb_scs8hd_rstseq_4;

    localparam int SS = 2;
    localparam int ND = 4;
    localparam int GP = 8;
    localparam int SL = 16;

    logic          CLK = 1'b0;
    logic          RESETB = 1'b0;
    logic          SWRST_REQ = 1'b0;
    logic          SWRST_ACK;
    logic [ND-1:0] RESETB_OUT;
    logic          READY;

    int checks = 0;
    int errors = 0;

    // Model: edges since reset release, edge at which the current release starts,
    // whether that release came from a software reset, and the ack level.
    int edge_n;
    int e0;
    bit sw_pend;
    bit m_ack;

    scs8hd_rstseq_4 #(
        .SYNC_STAGES(SS),
        .NDOM       (ND),
        .GAP        (GP),
        .SWRST_LEN  (SL)
    ) dut (
        .CLK       (CLK),
        .RESETB    (RESETB),
        .SWRST_REQ (SWRST_REQ),
        .SWRST_ACK (SWRST_ACK),
        .RESETB_OUT(RESETB_OUT),
        .READY     (READY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int released();
        int r = 0;
        for (int i = 0; i < ND; i++) begin
            if (edge_n >= e0 + (i + 1) * GP) r++;
        end
        return r;
    endfunction

    function automatic logic [31:0] therm(input int k);
        logic [31:0] v = '0;
        for (int i = 0; i < k; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        edge_n  = 0;
        e0      = SS + 1;
        sw_pend = 1'b0;
        m_ack   = 1'b0;
    endtask

    task automatic model_edge(input bit req);
        bit run_prev;
        run_prev = (edge_n >= e0 + ND * GP);
        edge_n++;
        if (run_prev) begin
            if (m_ack) begin
                if (!req) m_ack = 1'b0;
            end else if (req) begin
                e0      = edge_n + SL;
                sw_pend = 1'b1;
            end
        end
        if (sw_pend && edge_n == e0 + ND * GP) begin
            m_ack   = 1'b1;
            sw_pend = 1'b0;
        end
    endtask

    task automatic step();
        bit req_s;
        @(posedge CLK);
        req_s = SWRST_REQ;
        if (RESETB) model_edge(req_s);
        #1;
        chk("out", 32'(RESETB_OUT), therm(released()));
        chk("ready", 32'(READY), 32'(released() == ND));
        chk("ack", 32'(SWRST_ACK), 32'(m_ack));
        chk("thermo", 32'(RESETB_OUT) & (32'(RESETB_OUT) + 1), 32'd0);
    endtask

    // Short low pulse between edges; outputs must clear without a clock.
    task automatic glitch();
        #2;
        RESETB = 1'b0;
        #0.1;
        chk("async_out", 32'(RESETB_OUT), 32'd0);
        chk("async_ready", 32'(READY), 32'd0);
        chk("async_ack", 32'(SWRST_ACK), 32'd0);
        #0.2;
        RESETB = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) step();
        #3;
        RESETB = 1'b1;

        // Power-on release schedule.
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 10) chk("t1_e10", 32'(RESETB_OUT), 32'h0);
            if (n == 11) chk("t1_e11", 32'(RESETB_OUT), 32'h1);
            if (n == 19) chk("t1_e19", 32'(RESETB_OUT), 32'h3);
            if (n == 27) chk("t1_e27", 32'(RESETB_OUT), 32'h7);
            if (n == 34) chk("t1_rdy34", 32'(READY), 32'h0);
            if (n == 35) chk("t1_e35", 32'(RESETB_OUT), 32'hf);
            if (n == 35) chk("t1_rdy35", 32'(READY), 32'h1);
        end

        // Software reset, request held high through the ack.
        SWRST_REQ = 1'b1;
        for (int k = 0; k <= 48; k++) begin
            step();
            if (k == 0) chk("t2_out_r", 32'(RESETB_OUT), 32'h0);
            if (k == 0) chk("t2_rdy_r", 32'(READY), 32'h0);
            if (k == 23) chk("t2_out_r23", 32'(RESETB_OUT), 32'h0);
            if (k == 24) chk("t2_out_r24", 32'(RESETB_OUT), 32'h1);
            if (k == 47) chk("t2_ack_r47", 32'(SWRST_ACK), 32'h0);
            if (k == 48) chk("t2_out_r48", 32'(RESETB_OUT), 32'hf);
            if (k == 48) chk("t2_ack_r48", 32'(SWRST_ACK), 32'h1);
        end
        repeat (20) step();
        chk("t4_hold_ack", 32'(SWRST_ACK), 32'h1);
        chk("t4_hold_out", 32'(RESETB_OUT), 32'hf);
        SWRST_REQ = 1'b0;
        step();
        chk("t4_ackclr", 32'(SWRST_ACK), 32'h0);
        SWRST_REQ = 1'b1;
        step();
        chk("t4_rereq", 32'(RESETB_OUT), 32'h0);
        SWRST_REQ = 1'b0;

        // Abort the release with idx=2 by a short RESETB pulse.
        repeat (35) step();
        chk("t3_idx2", 32'(RESETB_OUT), 32'h3);
        glitch();
        for (int n = 1; n <= 36; n++) begin
            step();
            if (n == 11) chk("t3_e11", 32'(RESETB_OUT), 32'h1);
            if (n == 35) chk("t3_e35", 32'(RESETB_OUT), 32'hf);
        end

        // Request raised during HOLD/RELEASE is taken on the first RUN edge.
        glitch();
        SWRST_REQ = 1'b1;
        for (int n = 1; n <= 84; n++) begin
            step();
            if (n == 35) chk("t5_rdy35", 32'(READY), 32'h1);
            if (n == 35) chk("t5_ack35", 32'(SWRST_ACK), 32'h0);
            if (n == 36) chk("t5_out36", 32'(RESETB_OUT), 32'h0);
            if (n == 84) chk("t5_ack84", 32'(SWRST_ACK), 32'h1);
        end
        SWRST_REQ = 1'b0;

        // Random request toggling with occasional reset pulses.
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom_range(7) == 0) SWRST_REQ = ~SWRST_REQ;
            if ($urandom_range(499) == 0) glitch();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
